fifo_sync_ctrl: RTL

- Single-clock controller that sequences the team's dual-port FIFO storage array: registered read, 1-cycle read latency, both array clocks tied to clk.
- Owns write/read pointers, full/empty/level tracking and a 2-entry output skid buffer.
- Presents valid/ready streams on both sides, first-word-fall-through, sustained 1 word/cycle.
- Used wherever a same-clock buffer is needed on top of the shared storage array.

---
 rtl/fifo_sync_ctrl_pkg.sv | 16 +
 rtl/fifo_sync_ctrl_skid.sv | 67 ++++++
 rtl/fifo_sync_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/fifo_sync_ctrl_pkg.sv
// Shared widths, skid-buffer constants and occupancy type for the synchronous FIFO controller.
package fifo_sync_ctrl_pkg;

    localparam int SKID_DEPTH = 2;

    typedef logic [1:0] skid_occ_t;

    function automatic int ptr_w(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int lvl_w(input int addr_w);
        return addr_w + 2;
    endfunction

endpackage

// File: rtl/fifo_sync_ctrl_skid.sv
// Two-entry ordered output buffer; head entry drives the downstream stream.
module fifo_sync_ctrl_skid
    import fifo_sync_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    input  logic                  pop_i,
    output skid_occ_t             occupancy_o,
    output logic [DATA_WIDTH-1:0] head_data_o,
    output logic                  valid_o
);

    skid_occ_t             occ_q, occ_d;
    logic [DATA_WIDTH-1:0] data0_q, data0_d;
    logic [DATA_WIDTH-1:0] data1_q, data1_d;
    logic                  pop_eff;

    assign pop_eff = pop_i && (occ_q != 2'd0);

    always_comb begin
        occ_d   = occ_q;
        data0_d = data0_q;
        data1_d = data1_q;
        case ({load_i, pop_eff})
            2'b01: begin
                data0_d = data1_q;
                occ_d   = occ_q - 2'd1;
            end
            2'b10: begin
                if (occ_q == 2'd0) data0_d = load_data_i;
                else               data1_d = load_data_i;
                occ_d = occ_q + 2'd1;
            end
            2'b11: begin
                // Head leaves this edge, so a single survivor shifts forward ahead of the new word.
                if (occ_q == 2'(SKID_DEPTH)) begin
                    data0_d = data1_q;
                    data1_d = load_data_i;
                end else begin
                    data0_d = load_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) occ_q <= 2'd0;
        else     occ_q <= occ_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data0_q <= data0_d;
            data1_q <= data1_d;
        end
    end

    assign occupancy_o = occ_q;
    assign head_data_o = data0_q;
    assign valid_o     = (occ_q != 2'd0);

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Same-clock FIFO controller over a registered-read dual-port array, FWFT via a 2-entry skid.
// Optional threshold flags enabled by defining FIFO_SYNC_CTRL_THRESH_EN.
module fifo_sync_ctrl
    import fifo_sync_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
`ifdef FIFO_SYNC_CTRL_THRESH_EN
    ,
    parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2
`endif
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [DATA_WIDTH-1:0]          s_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [DATA_WIDTH-1:0]          m_data,
    output logic                           mem_wr_en,
    output logic [ADDR_WIDTH-1:0]          mem_wr_addr,
    output logic [DATA_WIDTH-1:0]          mem_wr_data,
    output logic [ADDR_WIDTH-1:0]          mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]          mem_rd_data,
    output logic                           full,
    output logic                           empty,
    output logic [lvl_w(ADDR_WIDTH)-1:0]   level
`ifdef FIFO_SYNC_CTRL_THRESH_EN
    ,
    output logic                           almost_full,
    output logic                           almost_empty
`endif
);

    localparam int PTR_W = ptr_w(ADDR_WIDTH);
    localparam int LVL_W = lvl_w(ADDR_WIDTH);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             rd_pending_q, rd_pending_d;
    logic [PTR_W-1:0] mem_cnt;
    logic [2:0]       inflight;
    logic             push, pop, issue;
    skid_occ_t        skid_occ;

    assign mem_cnt = wr_ptr_q - rd_ptr_q;
    assign full    = (mem_cnt == PTR_W'(DEPTH));
    assign s_ready = !full;
    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;

    // Only registered mem_cnt gates the read, so a word is never read in the cycle it is written.
    assign inflight = {1'b0, skid_occ} + {2'b00, rd_pending_q} - {2'b00, pop};
    assign issue    = (mem_cnt != '0) && (inflight < 3'(SKID_DEPTH));

    assign mem_wr_en   = push;
    assign mem_wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
    assign mem_wr_data = s_data;
    assign mem_rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

    always_comb begin
        wr_ptr_d     = wr_ptr_q + PTR_W'(push);
        rd_ptr_d     = rd_ptr_q + PTR_W'(issue);
        rd_pending_d = issue;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rd_pending_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_pending_q <= rd_pending_d;
        end
    end

    fifo_sync_ctrl_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .load_i      (rd_pending_q),
        .load_data_i (mem_rd_data),
        .pop_i       (pop),
        .occupancy_o (skid_occ),
        .head_data_o (m_data),
        .valid_o     (m_valid)
    );

    assign level = LVL_W'(mem_cnt) + LVL_W'(rd_pending_q) + LVL_W'(skid_occ);
    assign empty = (level == '0);

`ifdef FIFO_SYNC_CTRL_THRESH_EN
    logic almost_full_q, almost_empty_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            almost_full_q  <= (level >= LVL_W'(AF_LEVEL));
            almost_empty_q <= (level <= LVL_W'(AE_LEVEL));
        end
    end

    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
`else
    // Default build exposes no threshold flags.
`endif

endmodule
